// File: rtl/seq_gen_pkg.sv
// Shared types and defaults for the serial
// sequence generator.
package seq_gen_pkg;

    localparam int DEF_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/seq_piso.sv
// W-bit parallel-in / serial-out shift register,
// MSB first, load has priority over shift.
module seq_piso
    import seq_gen_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[W-2:0], 1'b0};
        end
    end

    assign msb = sr[W-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: captures a pattern,
// sends it MSB-first a programmed number of times.
module sequence_generator
    import seq_gen_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int GAP = 0,
    parameter int LW  = $clog2(W) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic [W-1:0]  pattern,
    input  logic [LW-1:0] len,
    input  logic [3:0]    reps,
    output logic          x,
    output logic          x_valid,
    output logic          busy,
    output logic          done
);

    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [LW-1:0] WL = LW'(W);

    state_t        state;
    state_t        state_n;
    logic [W-1:0]  pat_cap;
    logic [W-1:0]  load_val;
    logic [W-1:0]  piso_din;
    logic [LW-1:0] len_eff;
    logic [LW-1:0] len_cap;
    logic [LW-1:0] bit_cnt;
    logic [3:0]    reps_cap;
    logic [3:0]    rep_left;
    logic [GW-1:0] gap_cnt;
    logic          accept;
    logic          reload;
    logic          shift;
    logic          msb;

    // Left-align the pattern so its first bit sits at the MSB
    assign len_eff  = (len > WL) ? WL : len;
    assign load_val = pattern << (WL - len_eff);
    assign piso_din = accept ? load_val : pat_cap;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        reload  = 1'b0;
        shift   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start && !stop && len != '0) begin
                    accept  = 1'b1;
                    state_n = ST_SEND;
                end
            end
            ST_SEND: begin
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (bit_cnt == LW'(1)) begin
                    if (reps_cap == 4'd0 ||
                        rep_left > 4'd1) begin
                        reload  = 1'b1;
                        state_n = (GAP > 0) ? ST_GAP
                                            : ST_SEND;
                    end else begin
                        state_n = ST_DONE;
                    end
                end else begin
                    shift = 1'b1;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (gap_cnt == GW'(1)) begin
                    state_n = ST_SEND;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pat_cap  <= '0;
            len_cap  <= '0;
            bit_cnt  <= '0;
            reps_cap <= '0;
            rep_left <= '0;
            gap_cnt  <= '0;
        end else begin
            if (accept) begin
                pat_cap  <= load_val;
                len_cap  <= len_eff;
                bit_cnt  <= len_eff;
                reps_cap <= reps;
                rep_left <= reps;
            end else if (reload) begin
                bit_cnt <= len_cap;
                gap_cnt <= GW'(GAP);
                if (reps_cap != 4'd0) begin
                    rep_left <= rep_left - 4'd1;
                end
            end else if (shift) begin
                bit_cnt <= bit_cnt - LW'(1);
            end
            if (state == ST_GAP) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end

    seq_piso #(
        .W(W)
    ) u_piso (
        .clock(clock),
        .reset(reset),
        .load (accept | reload),
        .shift(shift),
        .din  (piso_din),
        .msb  (msb)
    );

    assign x_valid = (state == ST_SEND);
    assign x       = x_valid & msb;
    assign busy    = (state == ST_SEND) ||
                     (state == ST_GAP);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator
// (GAP=0 and GAP=2 instances).
module tb_sequence_generator;
    import seq_gen_pkg::*;

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic       start0 = 1'b0;
    logic       start2 = 1'b0;
    logic       stop   = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] len    = '0;
    logic [3:0] reps   = '0;
    logic       x0, v0, b0, d0;
    logic       x2, v2, b2, d2;

    always #5 clock = ~clock;

    sequence_generator #(.W(8), .GAP(0)) u0 (
        .clock(clock), .reset(reset),
        .start(start0), .stop(stop),
        .pattern(pattern), .len(len), .reps(reps),
        .x(x0), .x_valid(v0), .busy(b0), .done(d0)
    );

    sequence_generator #(.W(8), .GAP(2)) u2 (
        .clock(clock), .reset(reset),
        .start(start2), .stop(stop),
        .pattern(pattern), .len(len), .reps(reps),
        .x(x2), .x_valid(v2), .busy(b2), .done(d2)
    );

    typedef struct packed {
        logic x;
        logic v;
        logic b;
        logic d;
    } obs_t;

    typedef struct {
        logic [7:0]  pattern;
        logic [3:0]  len;
        logic [3:0]  reps;
        int          nbits;
        logic [31:0] bits;
    } vec_t;

    obs_t sbq[$];
    vec_t tbl[7];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   sel2   = 1'b0;

    function automatic obs_t cur();
        if (sel2) return obs_t'({x2, v2, b2, d2});
        return obs_t'({x0, v0, b0, d0});
    endfunction

    task automatic check(string name, obs_t got,
                         obs_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: x/v/b/d got %b required %b",
                     name, got, exp);
        end
    endtask

    task automatic push(bit xx, bit vv, bit bb, bit dd);
        sbq.push_back(obs_t'({xx, vv, bb, dd}));
    endtask

    task automatic step(string name);
        obs_t e;
        @(posedge clock);
        @(negedge clock);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check(name, cur(), e);
        end
    endtask

    task automatic drain(string name);
        int g = 0;
        while (sbq.size() != 0 && g < 100) begin
            step(name);
            g++;
        end
        if (sbq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: timeout, %0d left",
                     name, sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not end");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'h05, 4'd4,  4'd1, 4,  32'b0101};
        tbl[1] = '{8'hA5, 4'd12, 4'd1, 8,  32'hA5};
        tbl[2] = '{8'h03, 4'd3,  4'd2, 6,  32'b011011};
        tbl[3] = '{8'h01, 4'd1,  4'd3, 3,  32'b111};
        tbl[4] = '{8'hF0, 4'd8,  4'd1, 8,  32'hF0};
        tbl[5] = '{8'hC3, 4'd5,  4'd1, 5,  32'b00011};
        tbl[6] = '{8'h5A, 4'd8,  4'd3, 24, 32'h5A5A5A};

        // reset state
        #1;
        sel2 = 1'b0;
        check("reset_u0", cur(), obs_t'(4'b0));
        sel2 = 1'b1;
        check("reset_u2", cur(), obs_t'(4'b0));
        sel2 = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        push(0, 0, 0, 0);
        drain("idle_after_reset");

        // table: GAP=0 finite transmissions
        for (int i = 0; i < 7; i++) begin
            pattern = tbl[i].pattern;
            len     = tbl[i].len;
            reps    = tbl[i].reps;
            start0  = 1'b1;
            for (int j = tbl[i].nbits - 1; j >= 0; j--)
                push(tbl[i].bits[j], 1, 1, 0);
            push(0, 0, 0, 1);
            push(0, 0, 0, 0);
            step($sformatf("vec%0d", i));
            start0  = 1'b0;
            pattern = 8'hFF;
            len     = 4'd0;
            reps    = 4'd0;
            drain($sformatf("vec%0d", i));
        end

        // start held high: ignored in SEND/DONE
        pattern = 8'h05; len = 4'd4; reps = 4'd1;
        start0 = 1'b1;
        push(0,1,1,0); push(1,1,1,0);
        push(0,1,1,0); push(1,1,1,0);
        push(0,0,0,1); push(0,0,0,0);
        push(1,1,1,0); push(0,1,1,0);
        push(1,1,1,0); push(0,1,1,0);
        push(0,0,0,1); push(0,0,0,0);
        step("hold_start");
        pattern = 8'h0A;
        repeat (6) step("hold_start");
        start0 = 1'b0;
        drain("hold_start");

        // len=0 ignored
        pattern = 8'hFF; len = 4'd0; reps = 4'd1;
        start0 = 1'b1;
        repeat (3) push(0, 0, 0, 0);
        drain("len_zero");
        start0 = 1'b0;

        // start with stop in IDLE
        len = 4'd4; stop = 1'b1; start0 = 1'b1;
        repeat (2) push(0, 0, 0, 0);
        drain("start_stop");
        stop = 1'b0; start0 = 1'b0;

        // GAP=2, two repetitions
        sel2 = 1'b1;
        pattern = 8'hB6; len = 4'd8; reps = 4'd2;
        start2 = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int j = 7; j >= 0; j--)
                push(pattern[j], 1, 1, 0);
            if (r == 0) begin
                push(0, 0, 1, 0);
                push(0, 0, 1, 0);
            end
        end
        push(0, 0, 0, 1);
        push(0, 0, 0, 0);
        step("gap2");
        start2 = 1'b0;
        pattern = 8'h00;
        drain("gap2");

        // stop during GAP
        pattern = 8'h02; len = 4'd2; reps = 4'd0;
        start2 = 1'b1;
        push(1,1,1,0); push(0,1,1,0);
        push(0,0,1,0);
        push(0,0,0,0); push(0,0,0,0);
        step("stop_gap");
        start2 = 1'b0;
        step("stop_gap");
        step("stop_gap");
        stop = 1'b1;
        step("stop_gap");
        stop = 1'b0;
        drain("stop_gap");

        // continuous, stop at edge 7
        sel2 = 1'b0;
        pattern = 8'h02; len = 4'd2; reps = 4'd0;
        start0 = 1'b1;
        for (int k = 0; k < 7; k++)
            push(((k % 2) == 0), 1, 1, 0);
        push(0, 0, 0, 0);
        push(0, 0, 0, 0);
        step("cont");
        start0 = 1'b0;
        repeat (6) step("cont");
        stop = 1'b1;
        step("cont");
        stop = 1'b0;
        drain("cont");

        // reset in cycle 3 of an 8-bit send
        pattern = 8'hA5; len = 4'd8; reps = 4'd1;
        start0 = 1'b1;
        push(1,1,1,0); push(0,1,1,0); push(1,1,1,0);
        step("rst_mid");
        start0 = 1'b0;
        step("rst_mid");
        step("rst_mid");
        #2 reset = 1'b0;
        #1 check("rst_async", cur(), obs_t'(4'b0));
        sbq.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        push(0, 0, 0, 0);
        push(0, 0, 0, 0);
        drain("rst_nodone");
        pattern = 8'h3C; len = 4'd8; reps = 4'd1;
        start0 = 1'b1;
        for (int j = 7; j >= 0; j--)
            push(pattern[j], 1, 1, 0);
        push(0, 0, 0, 1);
        push(0, 0, 0, 0);
        step("rst_resend");
        start0 = 1'b0;
        drain("rst_resend");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sequence_generator.md
# sequence_generator

Serial bit-stream transmitter for the sequence-recognition path: captures a parallel pattern, emits it one bit per clock on a serial output, repeats it a programmed number of times, and reports completion. It is the source end of the single-bit `x` stream consumed by the sequence recognizer, and is used for stimulus generation and for loopback checks.

## Interface
- `W`, default 8: pattern width in bits.
- `GAP`, default 0: number of idle cycles inserted between repetitions.
- `LW`, default `$clog2(W)+1` (derived): width of `len`.

- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; low forces the reset state immediately.
- `start`  in  1  request to transmit; sampled only in IDLE.
- `stop`  in  1  abort request; sampled in SEND and GAP; in IDLE it suppresses `start`.
- `pattern`  in  W  bits to send, `pattern[len-1]` first, `pattern[0]` last; captured on an accepted `start`.
- `len`  in  LW  bits per repetition, 1..W; 0 makes `start` ignored; values above W clamp to W.
- `reps`  in  4  repetition count, 1..15; 0 means continuous until `stop`.
- `x`  out  1  serial data bit; 0 whenever `x_valid` is 0.
- `x_valid`  out  1  `x` carries a pattern bit this cycle.
- `busy`  out  1  high in SEND and GAP.
- `done`  out  1  one-cycle pulse after the final bit of the final repetition.

## Operation
- FSM states: IDLE, SEND, GAP, DONE. Outputs are registered (Moore), decoded from state and datapath registers.
- IDLE: if `start`=1, `stop`=0, and `len`≠0 at an edge, the block captures `pattern`, `min(len,W)`, and `reps`, loads the shift register with `pattern << (W-len)` so the first bit is at the MSB, loads the bit counter with `len`, and moves to SEND. Otherwise it stays in IDLE.
- SEND: `x` = shift register MSB and `x_valid`=1. Each edge shifts left by 1 and decrements the bit counter.
- End of a repetition (bit counter reaches 1 at an edge):
  - if `reps`=0, or the repetitions-left count is >1: decrement repetitions-left (not when `reps`=0), reload the shift register and bit counter from the captured copies, and go to GAP if `GAP`>0, otherwise stay in SEND with no bubble;
  - otherwise go to DONE.
- GAP: `x`=0, `x_valid`=0, `busy`=1. A gap counter runs `GAP` cycles, then the block returns to SEND.
- DONE: `done`=1, `busy`=0, `x_valid`=0 for exactly one cycle, then IDLE. `start` is not accepted in DONE.
- `stop`=1 at an edge in SEND or GAP: next state is IDLE with no `done` pulse. The bit presented in that cycle still counts as transmitted.
- Inputs are ignored while `busy` is high. `pattern`, `len`, and `reps` may change freely after capture.
- Reset: state IDLE; `x`, `x_valid`, `busy`, `done` = 0; all counters and the shift register cleared. Reset applied mid-transmission aborts with no `done` pulse.

## Timing
- Start accepted at edge k: first bit valid in cycle k+1; bit i in cycle k+1+i.
- One repetition occupies `len` cycles. Consecutive repetitions are separated by `GAP` cycles.
- Total for finite `reps`: `reps*len + (reps-1)*GAP` valid/gap cycles, then one `done` cycle, then IDLE.
- The earliest next accepted `start` is at the edge ending the DONE cycle's successor (the first IDLE cycle).
- `stop` at edge m: `x_valid`=0 from cycle m+1.

## Structure
- Shared package `seq_gen_pkg`: state encoding localparams (IDLE=2'b00, SEND=2'b01, GAP=2'b10, DONE=2'b11) and the default `W`.
- One natural sub-module: `seq_piso`, a W-bit parallel-in/serial-out shift register with load, shift enable, and MSB output. FSM, counters, and output decode live in `sequence_generator`.

## Test plan
- Reset low at any point -> `x`, `x_valid`, `busy`, `done` = 0 asynchronously; IDLE after release.
- `pattern`=8'h05, `len`=4, `reps`=1, `start` at edge 0 -> `x` = 0,1,0,1 in cycles 1-4 with `x_valid`=1; `done`=1 in cycle 5; IDLE in cycle 6. Looped into the recognizer, `z`=1 in cycle 3.
- `GAP`=2, `pattern`=8'hB6, `len`=8, `reps`=2 -> 1,0,1,1,0,1,1,0; two cycles with `x_valid`=0 and `busy`=1; the same 8 bits again; `done` in cycle 19.
- `reps`=0, `pattern`=8'h02, `len`=2 -> continuous 1,0,1,0…; `stop` at edge 7 -> `x_valid`=0 from cycle 8, no `done`.
- `len`=0 -> `start` ignored; `len`=12 -> clamped, 8 bits sent; `start` during SEND or DONE ignored; `start` and `stop` together in IDLE -> stays IDLE.
- Reset asserted in cycle 3 of an 8-bit send -> outputs 0 immediately, no `done`; after release, a new `start` sends a full pattern correctly.
